// File: rtl/pkt_comm_pkg.sv
// -----------------------------------------------------------------------------
// pkt_comm: constants and types shared by the output packet builders.
//   PKT_VERSION    default header byte 0
//   PKT_TYPE_INIT  header byte 1 for the INIT exchange
//   PKT_HDR_LEN    header length in bytes
//   PKT_CSUM_LEN   length of each checksum field in bytes
//   outpkt_state_e state encoding of the byte-serial packet builders
// -----------------------------------------------------------------------------
package pkt_comm;

  localparam logic [7:0] PKT_VERSION   = 8'd2;
  localparam logic [7:0] PKT_TYPE_INIT = 8'h05;
  localparam logic [3:0] PKT_HDR_LEN   = 4'd12;
  localparam logic [3:0] PKT_CSUM_LEN  = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HCSUM,
    ST_DATA,
    ST_DCSUM
  } outpkt_state_e;

endpackage

// File: rtl/outpkt_type_init_1b_if.sv
// -----------------------------------------------------------------------------
// outpkt_type_init_1b_if: core write port plus first-word-fall-through read
// port of the INIT packet builder.
//   din/wr_en/full   : core writes one payload byte when full=0
//   dout/rd_en/empty : packet bytes, consumed on rd_en & ~empty
// master = core/arbiter side, slave = packet builder.
// -----------------------------------------------------------------------------
interface outpkt_type_init_1b_if;

  logic [7:0] din;
  logic       wr_en;
  logic       full;
  logic [7:0] dout;
  logic       rd_en;
  logic       empty;

  modport master (
    output din, wr_en, rd_en,
    input  full, dout, empty
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, dout, empty
  );

endinterface

// File: rtl/pkt_csum32.sv
// -----------------------------------------------------------------------------
// pkt_csum32: running sum of a byte stream taken as little-endian 32-bit
// words, result inverted.
//   CLK, rst  : clock, synchronous active-high reset
//   i_start   : restart the sum with the current byte
//   i_en      : add the current byte to the sum
//   i_byte    : byte value
//   i_lane    : byte position inside its 32-bit word (0 = LSB)
//   o_csum    : ~sum, driven from the accumulator register
// -----------------------------------------------------------------------------
module pkt_csum32 (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_csum
);

  logic [31:0] r_sum;
  logic [31:0] w_term;

  // Summing words mod 2^32 equals summing each byte shifted into its lane.
  assign w_term = {24'h0, i_byte} << {i_lane, 3'b000};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_start) begin
      r_sum <= w_term;
    end else if (i_en) begin
      r_sum <= r_sum + w_term;
    end
  end

  assign o_csum = ~r_sum;

endmodule

// File: rtl/outpkt_type_init_1b.sv
// -----------------------------------------------------------------------------
// outpkt_type_init_1b: wraps each payload byte from the core into a complete
// PKT_TYPE_INIT packet and presents it byte-serially (FWFT) to the output
// packet FIFO / arbiter.
//   CLK  : clock, all logic on posedge
//   rst  : synchronous reset, active-high; aborts any packet in flight
//   bus  : slave side of outpkt_type_init_1b_if (din/wr_en/full, dout/rd_en/empty)
// Build option: define OUTPKT_INIT_CHECKSUM_EN to emit header and data
// checksums (21-byte packet); otherwise the packet is header + payload (13 B).
// -----------------------------------------------------------------------------
module outpkt_type_init_1b
  import pkt_comm::*;
#(
  parameter logic [7:0]  PKT_VERSION = pkt_comm::PKT_VERSION,
  parameter logic [7:0]  PKT_TYPE    = pkt_comm::PKT_TYPE_INIT,
  parameter logic [15:0] ID_INIT     = 16'd0
) (
  input logic                  CLK,
  input logic                  rst,
  outpkt_type_init_1b_if.slave bus
);

  outpkt_state_e r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_dout, w_dout_nxt;
  logic [7:0]    r_payload, w_payload_nxt;
  logic [15:0]   r_id;
  logic          r_full, w_full_nxt;
  logic          r_empty, w_empty_nxt;
  logic          w_rd, w_acc, w_last;

  assign w_rd      = bus.rd_en & ~r_empty;
  assign w_acc     = bus.wr_en & ~r_full;
  assign w_cnt_inc = r_cnt + 4'd1;

  // Header byte idx. r_id only advances after the last byte of a packet, so
  // reading it here is equivalent to the id captured at accept.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [15:0] id);
    case (idx)
      4'd0:    hdr_byte = PKT_VERSION;
      4'd1:    hdr_byte = PKT_TYPE;
      4'd4:    hdr_byte = 8'h01;        // payload length, LSB of 24-bit field
      4'd8:    hdr_byte = id[7:0];
      4'd9:    hdr_byte = id[15:8];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

`ifdef OUTPKT_INIT_CHECKSUM_EN
  logic [31:0] w_hcsum;
  logic [31:0] w_dcsum;
  logic        w_csum_start, w_csum_en;

  assign w_dcsum = ~{24'h0, r_payload};

  // Fed with each header byte as it is loaded into dout, so the sum is
  // complete (and registered) by the time the last header byte is consumed.
  pkt_csum32 u_hcsum (
    .CLK     (CLK),
    .rst     (rst),
    .i_start (w_csum_start),
    .i_en    (w_csum_en),
    .i_byte  (w_dout_nxt),
    .i_lane  (w_cnt_nxt[1:0]),
    .o_csum  (w_hcsum)
  );
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dout_nxt    = r_dout;
    w_payload_nxt = r_payload;
    w_full_nxt    = r_full;
    w_empty_nxt   = r_empty;
    w_last        = 1'b0;
`ifdef OUTPKT_INIT_CHECKSUM_EN
    w_csum_start  = 1'b0;
    w_csum_en     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (w_acc) begin
        w_state_nxt   = ST_HDR;
        w_cnt_nxt     = 4'd0;
        w_dout_nxt    = hdr_byte(4'd0, r_id);
        w_payload_nxt = bus.din;
        w_full_nxt    = 1'b1;
        w_empty_nxt   = 1'b0;
`ifdef OUTPKT_INIT_CHECKSUM_EN
        w_csum_start  = 1'b1;
`endif
      end
      ST_HDR: if (w_rd) begin
        if (r_cnt == PKT_HDR_LEN - 4'd1) begin
          w_cnt_nxt   = 4'd0;
`ifdef OUTPKT_INIT_CHECKSUM_EN
          w_state_nxt = ST_HCSUM;
          w_dout_nxt  = w_hcsum[7:0];
`else
          w_state_nxt = ST_DATA;
          w_dout_nxt  = r_payload;
`endif
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_dout_nxt = hdr_byte(w_cnt_inc, r_id);
`ifdef OUTPKT_INIT_CHECKSUM_EN
          w_csum_en  = 1'b1;
`endif
        end
      end
`ifdef OUTPKT_INIT_CHECKSUM_EN
      ST_HCSUM: if (w_rd) begin
        if (r_cnt == PKT_CSUM_LEN - 4'd1) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = 4'd0;
          w_dout_nxt  = r_payload;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_dout_nxt = w_hcsum[{w_cnt_inc[1:0], 3'b000} +: 8];
        end
      end
      ST_DATA: if (w_rd) begin
        w_state_nxt = ST_DCSUM;
        w_cnt_nxt   = 4'd0;
        w_dout_nxt  = w_dcsum[7:0];
      end
      ST_DCSUM: if (w_rd) begin
        if (r_cnt == PKT_CSUM_LEN - 4'd1) begin
          w_last = 1'b1;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_dout_nxt = w_dcsum[{w_cnt_inc[1:0], 3'b000} +: 8];
        end
      end
`else
      ST_DATA: if (w_rd) begin
        w_last = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // Last byte consumed: back to IDLE. dout keeps the last byte until the
    // next accept; it is not meaningful while empty=1.
    if (w_last) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
      w_full_nxt  = 1'b0;
      w_empty_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_dout    <= 8'h00;
      r_payload <= 8'h00;
      r_id      <= ID_INIT;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_payload <= w_payload_nxt;
      r_full    <= w_full_nxt;
      r_empty   <= w_empty_nxt;
      if (w_last) begin
        r_id <= r_id + 16'd1;   // wraps FFFF -> 0000
      end
    end
  end

  assign bus.full  = r_full;
  assign bus.empty = r_empty;
  assign bus.dout  = r_dout;

endmodule

// File: tb/tb_outpkt_type_init_1b.sv
// -----------------------------------------------------------------------------
// tb_outpkt_type_init_1b: two builders (ID_INIT 0000 and FFFF) driven by the
// same stimulus. A packet-level model (expected byte queue per builder) is
// compared against full/empty/dout on every negedge; directed tests add
// literal expectations on the consumed byte streams.
// Honours OUTPKT_INIT_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_outpkt_type_init_1b;

  localparam logic [15:0] ID0 = 16'h0000;
  localparam logic [15:0] ID1 = 16'hFFFF;
`ifdef OUTPKT_INIT_CHECKSUM_EN
  localparam int PKT_LEN = 21;
  localparam int PL_IDX  = 16;
`else
  localparam int PKT_LEN = 13;
  localparam int PL_IDX  = 12;
`endif

  typedef logic [7:0] bq_t [$];

  logic       CLK   = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;

  always #5 CLK = ~CLK;

  outpkt_type_init_1b_if bus0 ();
  outpkt_type_init_1b_if bus1 ();

  assign bus0.din   = din;
  assign bus0.wr_en = wr_en;
  assign bus0.rd_en = rd_en;
  assign bus1.din   = din;
  assign bus1.wr_en = wr_en;
  assign bus1.rd_en = rd_en;

  outpkt_type_init_1b #(.ID_INIT(ID0)) u_dut0 (.CLK(CLK), .rst(rst), .bus(bus0));
  outpkt_type_init_1b #(.ID_INIT(ID1)) u_dut1 (.CLK(CLK), .rst(rst), .bus(bus1));

  logic [7:0] dut_dout  [2];
  logic       dut_full  [2];
  logic       dut_empty [2];
  assign dut_dout[0]  = bus0.dout;
  assign dut_dout[1]  = bus1.dout;
  assign dut_full[0]  = bus0.full;
  assign dut_full[1]  = bus1.full;
  assign dut_empty[0] = bus0.empty;
  assign dut_empty[1] = bus1.empty;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet contents straight from the format rules.
  function automatic bq_t build_pkt(input logic [7:0] pl, input logic [15:0] id);
    logic [7:0] h [12];
    bq_t        q;
`ifdef OUTPKT_INIT_CHECKSUM_EN
    logic [31:0] sum;
`endif
    h = '{8'd2, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
          id[7:0], id[15:8], 8'h00, 8'h00};
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(h[i]);
`ifdef OUTPKT_INIT_CHECKSUM_EN
    sum = 32'h0;
    for (int n = 0; n < 3; n++) sum = sum + {h[4*n+3], h[4*n+2], h[4*n+1], h[4*n]};
    sum = ~sum;
    for (int b = 0; b < 4; b++) q.push_back(sum[8*b +: 8]);
`endif
    q.push_back(pl);
`ifdef OUTPKT_INIT_CHECKSUM_EN
    sum = ~{24'h0, pl};
    for (int b = 0; b < 4; b++) q.push_back(sum[8*b +: 8]);
`endif
    return q;
  endfunction

  // Model state: bytes still to be delivered, next id, captured DUT stream.
  bq_t        m_q   [2];
  logic [15:0] m_id [2];
  bq_t        cap   [2];
  logic       cmp_en = 1'b0;

  initial begin
    forever begin
      @(posedge CLK);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_q[k]  = {};
          m_id[k] = (k == 0) ? ID0 : ID1;
        end else begin
          if (rd_en && !dut_empty[k]) cap[k].push_back(dut_dout[k]);
          if (m_q[k].size() != 0) begin
            if (rd_en) begin
              void'(m_q[k].pop_front());
              if (m_q[k].size() == 0) m_id[k] = m_id[k] + 16'd1;
            end
          end else if (wr_en) begin
            m_q[k] = build_pkt(din, m_id[k]);
          end
        end
      end
    end
  end

  // Compare process. Inputs change at negedge+1, so at negedge rd_en/rst are
  // the values the last posedge used.
  logic [7:0] prev_dout [2];
  logic       prev_ne   [2];

  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("full%0d", k),  dut_full[k],  m_q[k].size() != 0);
          check($sformatf("empty%0d", k), dut_empty[k], m_q[k].size() == 0);
          if (m_q[k].size() != 0) check($sformatf("dout%0d", k), dut_dout[k], m_q[k][0]);
          if (prev_ne[k] && !rd_en && !rst && !dut_empty[k])
            check($sformatf("dout_hold%0d", k), dut_dout[k], prev_dout[k]);
          prev_dout[k] = dut_dout[k];
          prev_ne[k]   = !dut_empty[k];
        end
      end
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge CLK);
    #1;
    wr_en = w;
    din   = d;
    rd_en = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    cap[0] = {};
    cap[1] = {};
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end while (!(dut_empty[0] && dut_empty[1]) && n < 60);
    check({tag, "_drained"}, {31'h0, dut_empty[0] & dut_empty[1]}, 32'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         lit;
    bq_t         pin;
    int          n, rises, gap;
    logic [31:0] pat;

    // Model pinned against hand-computed bytes.
`ifdef OUTPKT_INIT_CHECKSUM_EN
    lit = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'hFC, 8'hFA, 8'hFF, 8'hFF, 8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'hFF};
`else
    lit = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'hA5};
`endif
    pin = build_pkt(8'hA5, 16'h0000);
    check("model_len", pin.size(), PKT_LEN);
    for (int i = 0; i < PKT_LEN; i++) check($sformatf("model_b%0d", i), pin[i], lit[i]);
    pin = build_pkt(8'h3C, 16'hABCD);
    check("model_id_lo", pin[8], 8'hCD);
    check("model_id_hi", pin[9], 8'hAB);

    // Reset state.
    do_reset();
    cmp_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_dout%0d", k),  dut_dout[k],  8'h00);
      check($sformatf("rst_empty%0d", k), dut_empty[k], 1'b1);
      check($sformatf("rst_full%0d", k),  dut_full[k],  1'b0);
    end

    // 1: single packet, continuous reads.
    step(1'b1, 8'hA5, 1'b0);
    drain("t1");
    check("t1_len", cap[0].size(), PKT_LEN);
    for (int i = 0; i < PKT_LEN; i++) check($sformatf("t1_b%0d", i), cap[0][i], lit[i]);
    check("t1_id1_lo", cap[1][8], 8'hFF);
    check("t1_id1_hi", cap[1][9], 8'hFF);

    // 2 + id wrap: back-to-back packets with wr_en held.
    do_reset();
    wr_en = 1'b1; din = 8'h3C; rd_en = 1'b1;
    n = 0; rises = 0; gap = 0;
    do begin
      @(negedge CLK);
      #1;
      if (dut_full[0] && (rises == 0 || gap > 0) && rises < 2 && cap[0].size() % PKT_LEN == 0)
        rises++;
      if (rises == 1 && !dut_full[0]) gap++;
      if (rises == 2) wr_en = 1'b0;
      n++;
    end while (!(rises == 2 && dut_empty[0]) && n < 80);
    rd_en = 1'b0;
    check("t2_two_packets", rises, 2);
    check("t2_full_low_cycles", gap, 1);
    check("t2_len", cap[0].size(), 2 * PKT_LEN);
    check("t2_id0_second_lo", cap[0][PKT_LEN + 8], 8'h01);
    check("t2_id0_second_hi", cap[0][PKT_LEN + 9], 8'h00);
    check("t2_payload", cap[0][PKT_LEN + PL_IDX], 8'h3C);
    check("t6_id1_first_lo", cap[1][8], 8'hFF);
    check("t6_id1_first_hi", cap[1][9], 8'hFF);
    check("t6_id1_second_lo", cap[1][PKT_LEN + 8], 8'h00);
    check("t6_id1_second_hi", cap[1][PKT_LEN + 9], 8'h00);

    // 3: read strobe with gaps.
    do_reset();
    pat = 32'b1011_0011_0100_1110_0101_1001_1100_0110;
    step(1'b1, 8'h5E, 1'b0);
    n = 0;
    do begin
      step(1'b0, 8'h5E, pat[n % 32]);
      n++;
    end while (!dut_empty[0] && n < 100);
    rd_en = 1'b0;
    check("t3_len", cap[0].size(), PKT_LEN);
    check("t3_first", cap[0][0], 8'h02);
    check("t3_payload", cap[0][PL_IDX], 8'h5E);

    // 4: writes while busy are ignored.
    do_reset();
    step(1'b1, 8'h22, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      #1;
      wr_en = dut_full[0];
      din   = 8'h11;
      rd_en = 1'b1;
      n++;
    end while (dut_full[0] && n < 60);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    rd_en = 1'b0;
    check("t4_len", cap[0].size(), PKT_LEN);
    check("t4_payload", cap[0][PL_IDX], 8'h22);
    check("t4_idle_empty", dut_empty[0], 1'b1);
    check("t4_idle_full", dut_full[0], 1'b0);

    // 5: reset after 7 bytes, then a fresh packet.
    do_reset();
    step(1'b1, 8'h77, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b1);
    @(negedge CLK);
    #1;
    rst = 1'b1; rd_en = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check("t5_bytes_before_rst", cap[0].size(), 7);
    check("t5_empty", dut_empty[0], 1'b1);
    check("t5_full", dut_full[0], 1'b0);
    cap[0] = {};
    cap[1] = {};
    step(1'b1, 8'h78, 1'b0);
    drain("t5");
    check("t5_len", cap[0].size(), PKT_LEN);
    check("t5_first", cap[0][0], 8'h02);
    check("t5_id0_lo", cap[0][8], 8'h00);
    check("t5_id0_hi", cap[0][9], 8'h00);
    check("t5_id1_lo", cap[1][8], 8'hFF);
    check("t5_id1_hi", cap[1][9], 8'hFF);
    check("t5_payload", cap[0][PL_IDX], 8'h78);

    repeat (3) step(1'b0, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
